load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory responder for the decoder's memory control outputs (mem_read, mem_write, mem_size, mem_unsigned).
- Accepts one load/store request at a time. Checks size and alignment, then drives a word-addressed data-memory bus with byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data for register writeback.
- Sits in the execute/memory stage between the ALU address output and the data memory.

Parameters:
- ADDR_W, 32, width of the byte address and of dmem_addr.
- TIMEOUT_CYCLES, 255, number of ACCESS cycles without dmem_ack before a timeout fault is raised; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- mem_unsigned  in  1  zero-extend loads
- addr  in  ADDR_W  byte address
- store_data  in  32  rs2 value
- rd_addr  in  5  load destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  bus completion; rdata is valid in the same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- done  out  1  one-cycle pulse; request retired, with or without fault
- fault  out  1  one-cycle pulse, coincident with done
- fault_cause  out  2  1 = misaligned, 2 = timeout, 3 = illegal request; 0 when there is no fault

Behaviour:
- Reset (asynchronous):
  - Enter IDLE.
  - All outputs go to 0 immediately, including req_ready and dmem_req.
  - Timeout counter clears.
  - Asserting reset mid-ACCESS drops dmem_req in the same cycle. No done or wb_valid is produced for the aborted request.
- States: IDLE, ACCESS, RESP, FAULT.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid && req_ready at a rising edge.
  - Addr, size, unsigned flag, data and rd are registered at accept.
- Illegal request:
  - Condition: mem_read == mem_write (both 1, or both 0), or mem_size == 3.
  - Action: go to FAULT with cause 3.
- Misaligned request:
  - Condition: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Action: go to FAULT with cause 1.
  - No bus activity occurs for any faulting request.
- Otherwise: go to ACCESS.
- ACCESS:
  - dmem_req = 1 from the cycle after accept.
  - dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and held stable until dmem_ack is sampled high.
  - On ack: dmem_req drops on the next edge and the state moves to RESP. Ack in the first ACCESS cycle is legal.
- Timeout:
  - The counter increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req and go to FAULT with cause 2.
  - If ack arrives in the same cycle as the timeout, ack wins and no fault is raised.
- Store lanes:
  - byte: wdata = {4{sd[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{sd[15:0]}}, be = 4'b0011 << addr[1:0].
  - word: wdata = sd, be = 4'b1111.
- Loads:
  - be = 4'b1111 and dmem_we = 0.
  - The lane is selected by addr[1:0] from dmem_rdata captured at ack.
  - The lane is sign-extended unless mem_unsigned = 1, in which case it is zero-extended.
- RESP (one cycle):
  - done = 1.
  - For loads only, wb_valid = 1 with wb_rd and wb_data valid.
  - rd = 0 is still reported; the register file ignores it.
  - Return to IDLE.
- FAULT (one cycle): done = 1, fault = 1, fault_cause valid; return to IDLE.
- wb_data, wb_rd and fault_cause hold their values until the next retirement. Only the pulses return to 0.
- req_ready = 0 in ACCESS, RESP and FAULT. Minimum throughput is one request per 3 cycles.
- dmem_ack seen while not in ACCESS is ignored.
- Latency from accept to done:
  - 2 cycles with ack in the first ACCESS cycle.
  - 1 cycle for a faulting request.

Test Plan:
- Signed byte load: addr = 0x1003, size 0, unsigned 0, rdata = 0x80AABBCC, ack in the first ACCESS cycle -> dmem_addr = 0x1000, be = 0xF; wb_data = 0xFFFFFF80, wb_rd = rd, wb_valid 2 cycles after accept.
- Half store: addr = 0x2002, sd = 0x1234ABCD, ack delayed 3 cycles -> wdata = 0xABCDABCD, be = 0xC, we = 1, signals stable until ack; done with no wb_valid.
- Misaligned word load: addr = 0x3001 -> no dmem_req; next cycle fault = 1, cause = 1, done = 1; req_ready returns to 1.
- Illegal requests: mem_size = 3, or mem_read = mem_write = 1 -> fault cause 3, no bus activity.
- Timeout: TIMEOUT_CYCLES = 4, no ack -> dmem_req high for 4 cycles, then drops; fault cause 2. A repeat run with ack on the 4th cycle -> normal RESP, no fault.
- Reset mid-operation: assert rst during ACCESS with dmem_req = 1 -> dmem_req = 0 asynchronously, no done; after release, a new unsigned half load at 0x10 with rdata = 0x0000F00D -> wb_data = 0x0000F00D.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: checks each request for legality and alignment, then runs
// one word-addressed data-memory transaction and returns the extended load data.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic [1:0]  lane_off;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        is_load_q;
  logic [4:0]  rd_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    illegal    = (mem_read == mem_write) || (mem_size == 2'd3);
    misaligned = ((mem_size == SZ_HALF) && addr[0]) ||
                 ((mem_size == SZ_WORD) && (addr[1:0] != 2'b00));
    wdata_next = store_data;
    be_next    = 4'b1111;
    case (mem_size)
      SZ_BYTE: begin
        wdata_next = {4{store_data[7:0]}};
        be_next    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        wdata_next = {2{store_data[15:0]}};
        be_next    = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
    if (mem_read) be_next = 4'b1111;
  end

  always_comb begin
    byte_lane = dmem_rdata[{lane_off, 3'b000} +: 8];
    half_lane = lane_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_ext = dmem_rdata;
    endcase
  end

  // req_ready is registered, so it rises on the first edge after reset release.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      lane_off    <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      is_load_q   <= 1'b0;
      rd_q        <= '0;
      req_ready   <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      done     <= 1'b0;
      fault    <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            lane_off   <= addr[1:0];
            size_q     <= mem_size;
            unsigned_q <= mem_unsigned;
            is_load_q  <= mem_read;
            rd_q       <= rd_addr;
            if (illegal || misaligned) begin
              state       <= S_FAULT;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state      <= S_ACCESS;
              tmo_cnt    <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              dmem_wdata <= wdata_next;
              dmem_be    <= be_next;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (dmem_ack) begin
            state       <= S_RESP;
            dmem_req    <= 1'b0;
            done        <= 1'b1;
            fault_cause <= CAUSE_NONE;
            if (is_load_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= load_ext;
            end
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            state       <= S_FAULT;
            dmem_req    <= 1'b0;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: legal loads/stores, faults, timeout and
// asynchronous reset, with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .store_data(store_data),
    .rd_addr(rd_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let the next edge accept it, then withdraw it.
  task automatic issue(input logic rd_i, input logic wr_i, input logic [1:0] sz,
                       input logic un, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd);
    check("ready_before_issue", req_ready, 1);
    req_valid    = 1'b1;
    mem_read     = rd_i;
    mem_write    = wr_i;
    mem_size     = sz;
    mem_unsigned = un;
    addr         = a;
    store_data   = sd;
    rd_addr      = rd;
    step();
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // A request that must fault without touching the bus.
  task automatic fault_case(input string tag, input logic rd_i, input logic wr_i,
                            input logic [1:0] sz, input logic [31:0] a,
                            input logic [1:0] cause);
    issue(rd_i, wr_i, sz, 1'b0, a, 32'h0, 5'd1);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_fault"}, fault, 1);
    check({tag, "_cause"}, fault_cause, cause);
    check({tag, "_busy"}, req_ready, 0);
    step();
    check({tag, "_done_clr"}, {done, fault, wb_valid}, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_cause_hold"}, fault_cause, cause);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
    mem_unsigned = 1'b0; addr = '0; store_data = '0; rd_addr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #3;
    check("rst_outputs", {req_ready, dmem_req, done, fault, wb_valid, fault_cause}, 0);
    step();
    rst = 1'b0;
    step();
    check("ready_after_rst", req_ready, 1);

    // Ack outside ACCESS must not retire anything.
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("stray_ack", {done, wb_valid, dmem_req}, 0);

    // Signed byte load, ack in the first ACCESS cycle.
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 5'd5);
    check("lb_req", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h0000_1000);
    check("lb_be", dmem_be, 4'hF);
    check("lb_we", dmem_we, 0);
    check("lb_busy", req_ready, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80AA_BBCC;
    step();
    dmem_ack = 1'b0;
    check("lb_done", {done, wb_valid, fault}, 3'b110);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_rd", wb_rd, 5'd5);
    check("lb_req_drop", dmem_req, 0);
    step();
    check("lb_pulse_clr", {done, wb_valid}, 0);
    check("lb_data_hold", wb_data, 32'hFFFF_FF80);

    // Half store with a 3-cycle ack delay; bus fields must stay put.
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("sh_req", dmem_req, 1);
      check("sh_bus", {dmem_we, dmem_be, dmem_wdata, dmem_addr[15:0]},
            {1'b1, 4'hC, 32'hABCD_ABCD, 16'h2000});
      check("sh_no_done", done, 0);
      step();
    end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sh_done", {done, wb_valid, fault, dmem_req}, 4'b1000);
    step();

    // Signed half load from the upper lane, ack after one wait cycle.
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0, 5'd9);
    check("lh_addr", dmem_addr, 32'h0000_0004);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
    step();
    dmem_ack = 1'b0;
    check("lh_data", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd9, 32'hFFFF_8001});
    step();

    // Byte store lane placement.
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_005A, 5'd0);
    check("sb_bus", {dmem_be, dmem_wdata}, {4'b0010, 32'h5A5A_5A5A});
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    step();

    fault_case("mis_lw", 1'b1, 1'b0, 2'd2, 32'h0000_3001, 2'd1);
    fault_case("mis_sh", 1'b0, 1'b1, 2'd1, 32'h0000_0005, 2'd1);
    fault_case("ill_size", 1'b1, 1'b0, 2'd3, 32'h0000_0000, 2'd3);
    fault_case("ill_rw", 1'b1, 1'b1, 2'd2, 32'h0000_0000, 2'd3);
    fault_case("ill_none", 1'b0, 1'b0, 2'd0, 32'h0000_0000, 2'd3);

    // Timeout after 4 ACCESS cycles with no ack.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      check("to_req", {dmem_req, done}, 2'b10);
      step();
    end
    check("to_fault", {dmem_req, done, fault, wb_valid, fault_cause}, {4'b0110, 2'd2});
    step();

    // Ack in the 4th cycle wins over the timeout.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 5'd4);
    for (int i = 0; i < 3; i++) begin
      check("ack4_req", dmem_req, 1);
      step();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    check("ack4_resp", {done, fault, wb_valid, fault_cause}, {3'b101, 2'd0});
    check("ack4_data", wb_data, 32'hDEAD_BEEF);
    step();

    // Asynchronous reset during ACCESS.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 5'd7);
    check("rst_mid_req", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_async", {dmem_req, req_ready, done}, 0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("rst_mid_no_done", {done, wb_valid, dmem_req}, 0);
    rst = 1'b0;
    step();
    check("rst_mid_ready", {req_ready, done}, 2'b10);

    // Unsigned half load after reset.
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0, 5'd2);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_F00D;
    step();
    dmem_ack = 1'b0;
    check("lhu_data", {wb_valid, wb_data}, {1'b1, 32'h0000_F00D});
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
